// File: rtl/vec_reverse_arbiter.sv
// Two-requester round-robin arbiter feeding one registered bit-reversal stage.
// Latency: 1 cycle from accept to out_valid; one word per cycle when out_ready stays high.
// Backpressure: while the output is held, both readies stay low and nothing is counted.
module vec_reverse_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state;
  logic             last_grant;
  logic             slot_free;
  logic             grant_vld;
  logic             grant_sel;
  logic [WIDTH-1:0] grant_data;
  logic [WIDTH-1:0] grant_rev;

  // Reset gates the slot so no requester sees ready while reset is held.
  assign slot_free  = ~reset & ((state == ST_EMPTY) | out_ready);
  assign grant_vld  = slot_free & (req0_valid | req1_valid);
  assign grant_sel  = req1_valid & (~req0_valid | ~last_grant);
  assign grant_data = grant_sel ? req1_data : req0_data;

  assign req0_ready = grant_vld & ~grant_sel;
  assign req1_ready = grant_vld &  grant_sel;
  assign out_valid  = (state == ST_FULL);

  always_comb begin
    grant_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      grant_rev[i] = grant_data[WIDTH-1-i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      out_data   <= '0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
      cnt0       <= '0;
      cnt1       <= '0;
    end else if (grant_vld) begin
      state      <= ST_FULL;
      out_data   <= grant_rev;
      out_src    <= grant_sel;
      last_grant <= grant_sel;
      if (!grant_sel && (cnt0 != {CNT_W{1'b1}})) cnt0 <= cnt0 + 1'b1;
      if ( grant_sel && (cnt1 != {CNT_W{1'b1}})) cnt1 <= cnt1 + 1'b1;
    end else if ((state == ST_FULL) && out_ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule
